// File: rtl/pool_engine_pkg.sv
// Shared types and elaboration-time helpers for the pooling engine.
package pool_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result = 0;
    int v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Output plane edge for a square input, window and stride.
  function automatic int ofm_size(input int ifm, input int k, input int s);
    return (ifm - k) / s + 1;
  endfunction

  // Width that holds the signed sum of k*k pixels without overflow.
  function automatic int sum_width(input int dw, input int k);
    return dw + clog2(k * k);
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One row of pixel history: an IFM_SIZE-deep delay line that advances on
// every accepted beat, so dout is the pixel one row above the current one.
module pool_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 27
) (
  input  logic                  clk1,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] taps [IFM_SIZE];

  // Shift the row history; a plane or frame start wipes it.
  // NOTE: storage arrays take no async reset; every frame begins with a start
  // pulse that clears them synchronously, and nothing reads them before that.
  // NOTE: non-blocking assignments here let every tap read its neighbour's
  // pre-edge value, giving a true shift instead of a ripple-through.
  always_ff @(posedge clk1) begin
    if (clear) begin
      for (int i = 0; i < IFM_SIZE; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < IFM_SIZE; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[IFM_SIZE-1];

endmodule

// File: rtl/pool_engine.sv
// Streaming max/average pooling over CI square planes.
// Optional build macro POOL_ENGINE_AVG_EN adds the average datapath; without
// it avg_mode is ignored and every window reduces by signed maximum.
module pool_engine
  import pool_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 27,
  parameter int KERNEL_POOL = 3,
  parameter int STRIDE_POOL = 2,
  parameter int CI          = 8
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  start_pool,
  input  logic                  avg_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ifm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  out_last,
  output logic                  end_pool,
  output logic                  busy
);

  localparam int K        = KERNEL_POOL;
  localparam int S        = STRIDE_POOL;
  localparam int OFM      = ofm_size(IFM_SIZE, K, S);
  localparam int LAST_OUT = K - 1 + (OFM - 1) * S;
  localparam int CW       = cnt_width(IFM_SIZE);
  localparam int CHW      = cnt_width(CI);

  state_t state, state_next;

  logic [CW-1:0]  col, row;
  logic [CHW-1:0] ch;
  logic col_last, row_last, ch_last, plane_last, frame_last;
  logic row_hit, col_hit, emit, emit_last;
  logic accept, out_hs, win_clear;

  logic [DATA_WIDTH-1:0]        lb_tap   [K];
  logic signed [DATA_WIDTH-1:0] win      [K][K];
  logic signed [DATA_WIDTH-1:0] win_next [K][K];
  logic signed [DATA_WIDTH-1:0] max_val;
  logic signed [DATA_WIDTH-1:0] pool_result;

  // A start pulse always wins over a beat offered in the same cycle.
  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready && !start_pool;
  assign out_hs     = out_valid && out_ready;
  assign busy       = (state != IDLE);

  assign col_last   = (col == CW'(IFM_SIZE - 1));
  assign row_last   = (row == CW'(IFM_SIZE - 1));
  assign ch_last    = (ch == CHW'(CI - 1));
  assign plane_last = col_last && row_last;
  assign frame_last = plane_last && ch_last;

  // The current beat completes a window once K rows/cols are in and it sits
  // on the stride grid.
  assign row_hit    = (int'(row) >= K - 1) && (((int'(row) - (K - 1)) % S) == 0);
  assign col_hit    = (int'(col) >= K - 1) && (((int'(col) - (K - 1)) % S) == 0);
  assign emit       = row_hit && col_hit;
  assign emit_last  = ch_last && (row == CW'(LAST_OUT)) && (col == CW'(LAST_OUT));

  // History is stale at every plane boundary and on any (re)start.
  assign win_clear  = start_pool || (accept && plane_last);

  // FSM state register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and the end-of-frame pulse.
  // NOTE: every output of this block is defaulted first so no path through the
  // case statement leaves a value held, which would infer a latch.
  always_comb begin
    state_next = state;
    end_pool   = 1'b0;
    case (state)
      IDLE: if (start_pool) state_next = RUN;
      RUN: begin
        if (start_pool)                state_next = RUN;
        else if (accept && frame_last) state_next = DONE;
      end
      DONE: begin
        if ((out_hs && out_last) || !out_valid) begin
          end_pool   = 1'b1;
          state_next = IDLE;
        end
        if (start_pool) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Column, row and channel position of the next beat.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (start_pool) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
          ch  <= ch_last ? '0 : ch + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers: lb_tap[n] is the pixel n rows above the current beat.
  assign lb_tap[0] = ifm;
  for (genvar g = 0; g < K - 1; g++) begin : g_line
    pool_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .IFM_SIZE  (IFM_SIZE)
    ) u_line (
      .clk1    (clk1),
      .shift_en(accept),
      .clear   (win_clear),
      .din     (lb_tap[g]),
      .dout    (lb_tap[g+1])
    );
  end

  // Window after this beat: older columns slide left, the new column enters
  // on the right with the oldest row at index 0.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) win_next[i][j] = win[i][j+1];
    end
    for (int i = 0; i < K; i++) win_next[i][K-1] = lb_tap[K-1-i];
  end

  // Register window; holds the K-1 most recent columns plus one of slack.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else if (win_clear) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= win_next[i][j];
    end
  end

  // Signed maximum over the completed window.
  always_comb begin
    max_val = win_next[0][0];
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (win_next[i][j] > max_val) max_val = win_next[i][j];
  end

`ifdef POOL_ENGINE_AVG_EN
  localparam int SUM_W = sum_width(DATA_WIDTH, K);
  localparam logic signed [SUM_W-1:0] WIN_AREA = SUM_W'(K * K);

  logic                         avg_q;
  logic signed [SUM_W-1:0]      win_sum;
  logic signed [DATA_WIDTH-1:0] avg_val;

  // Mode is latched on the start pulse and held for the whole frame.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)          avg_q <= 1'b0;
    else if (start_pool) avg_q <= avg_mode;
  end

  // Widened signed sum; signed division truncates toward zero.
  always_comb begin
    win_sum = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) win_sum = win_sum + SUM_W'(win_next[i][j]);
    avg_val = DATA_WIDTH'(win_sum / WIN_AREA);
  end

  assign pool_result = avg_q ? avg_val : max_val;
`else
  logic avg_mode_unused;
  assign avg_mode_unused = avg_mode;
  assign pool_result     = max_val;
`endif

  // Single-entry output register; holds steady while stalled.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      data_output <= '0;
    end else if (start_pool) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept && emit) begin
      out_valid   <= 1'b1;
      out_last    <= emit_last;
      data_output <= pool_result;
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine at IFM_SIZE=5, KERNEL_POOL=3, STRIDE_POOL=2,
// CI=2. Average expectations follow POOL_ENGINE_AVG_EN; without it they fall
// back to the max-mode results.
module tb_pool_engine;

  localparam int DW  = 32;
  localparam int IFM = 5;
  localparam int K   = 3;
  localparam int S   = 2;
  localparam int CI  = 2;

  logic          clk1 = 1'b0;
  logic          rst_n, start_pool, avg_mode, in_valid, out_ready;
  logic          in_ready, out_valid, out_last, end_pool, busy;
  logic [DW-1:0] ifm, data_output;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] out_q [$];
  logic          last_q [$];
  int            end_cnt = 0;
  int            beat_cnt = 0;
  int            bad_end = 0;

  pool_engine #(
    .DATA_WIDTH (DW),
    .IFM_SIZE   (IFM),
    .KERNEL_POOL(K),
    .STRIDE_POOL(S),
    .CI         (CI)
  ) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start_pool (start_pool),
    .avg_mode   (avg_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ifm        (ifm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_output(data_output),
    .out_last   (out_last),
    .end_pool   (end_pool),
    .busy       (busy)
  );

  always #5 clk1 = ~clk1;

  // Inputs change just after rising edges, so values seen on the falling edge
  // are the ones the next rising edge will act on.
  always @(negedge clk1) begin
    if (out_valid && out_ready) begin
      out_q.push_back(data_output);
      last_q.push_back(out_last);
    end
    if (in_valid && in_ready && !start_pool) beat_cnt <= beat_cnt + 1;
    if (end_pool) begin
      end_cnt <= end_cnt + 1;
      if (!(out_valid && out_ready && out_last)) bad_end <= bad_end + 1;
    end
  end

  // kind 0: ramp 5r+c in every plane.
  // kind 1: plane 0 is -1 except (0,0)=0; plane 1 is all -7.
  function automatic logic [DW-1:0] pix(input int kind, input int ch, input int r, input int c);
    if (kind == 0) return DW'(5 * r + c);
    if (ch == 0) return (r == 0 && c == 0) ? '0 : '1;
    return DW'(-7);
  endfunction

  task automatic drive_beat(input logic [DW-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    ifm      = v;
    @(negedge clk1);
    while (!in_ready && guard < 100) begin
      @(negedge clk1);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL beat_timeout: in_ready stayed 0, want 1");
    end
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind);
    for (int ch = 0; ch < CI; ch++)
      for (int r = 0; r < IFM; r++)
        for (int c = 0; c < IFM; c++) drive_beat(pix(kind, ch, r, c));
  endtask

  task automatic do_start(input logic avg);
    @(posedge clk1); #1;
    start_pool = 1'b1;
    avg_mode   = avg;
    @(posedge clk1); #1;
    start_pool = 1'b0;
  endtask

  task automatic wait_end(input int target);
    int guard = 0;
    while (end_cnt < target && guard < 500) begin
      @(negedge clk1);
      guard++;
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL end_timeout: end_pool count %0d, want %0d", end_cnt, target);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_pool = 1'b0; avg_mode = 1'b0;
    in_valid = 1'b0; ifm = '0; out_ready = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL reset_in_ready: got %b, want 0", in_ready); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    checks++; if (out_last !== 1'b0)    begin errors++; $display("FAIL reset_out_last: got %b, want 0", out_last); end
    checks++; if (end_pool !== 1'b0)    begin errors++; $display("FAIL reset_end_pool: got %b, want 0", end_pool); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    checks++; if (data_output !== '0)   begin errors++; $display("FAIL reset_data: got %0d, want 0", data_output); end
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic test_max_ramp();
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
    int qb = out_q.size();
    int eb = end_cnt;
    int bb = beat_cnt;
    out_ready = 1'b1;
    do_start(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL max_busy: got %b, want 1", busy); end
    send_frame(0);
    wait_end(eb + 1);
    checks++;
    if (out_q.size() - qb != 8) begin
      errors++; $display("FAIL max_count: got %0d outputs, want 8", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i] || last_q[qb+i] !== (i == 7)) begin
          errors++;
          $display("FAIL max_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i]), i == 7);
        end
      end
    end
    checks++; if (end_cnt - eb != 1)  begin errors++; $display("FAIL max_end_cnt: got %0d, want 1", end_cnt - eb); end
    checks++; if (bad_end != 0)       begin errors++; $display("FAIL max_end_align: got %0d stray end_pool, want 0", bad_end); end
    checks++; if (beat_cnt - bb != 50) begin errors++; $display("FAIL max_beats: got %0d, want 50", beat_cnt - bb); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL max_idle_busy: got %b, want 0", busy); end
  endtask

  task automatic test_avg_ramp();
`ifdef POOL_ENGINE_AVG_EN
    logic [DW-1:0] exp [8] = '{6, 8, 16, 18, 6, 8, 16, 18};
`else
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
`endif
    int qb = out_q.size();
    int eb = end_cnt;
    out_ready = 1'b1;
    do_start(1'b1);
    avg_mode = 1'b0;
    send_frame(0);
    wait_end(eb + 1);
    checks++;
    if (out_q.size() - qb != 8) begin
      errors++; $display("FAIL avg_count: got %0d outputs, want 8", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i] || last_q[qb+i] !== (i == 7)) begin
          errors++;
          $display("FAIL avg_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i]), i == 7);
        end
      end
    end
  endtask

  task automatic test_negative();
    // Window (2,2) of plane 0 sums to -8: max 0, average truncates to 0.
    logic [DW-1:0] exp [8] = '{0, -1, -1, -1, -7, -7, -7, -7};
    for (int m = 0; m < 2; m++) begin
      int qb = out_q.size();
      int eb = end_cnt;
      out_ready = 1'b1;
      do_start(m[0]);
      send_frame(1);
      wait_end(eb + 1);
      checks++;
      if (out_q.size() - qb != 8) begin
        errors++; $display("FAIL neg_count_m%0d: got %0d outputs, want 8", m, out_q.size() - qb);
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (out_q[qb+i] !== exp[i]) begin
            errors++;
            $display("FAIL neg_out_m%0d_%0d: got %0d, want %0d",
                     m, i, $signed(out_q[qb+i]), $signed(exp[i]));
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
    int qb = out_q.size();
    int eb = end_cnt;
    int bb = beat_cnt;
    out_ready = 1'b0;
    do_start(1'b0);
    fork
      send_frame(0);
      begin
        int g = 0;
        while (!out_valid && g < 200) begin
          @(negedge clk1);
          g++;
        end
        if (g >= 200) begin
          checks++; errors++;
          $display("FAIL bp_first_out: out_valid stayed 0, want 1");
        end
        for (int i = 0; i < 10; i++) begin
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_output !== 32'd12) begin
            errors++;
            $display("FAIL bp_stall%0d: got in_ready=%b out_valid=%b data=%0d, want 0 1 12",
                     i, in_ready, out_valid, $signed(data_output));
          end
          @(negedge clk1);
        end
        @(posedge clk1); #1;
        out_ready = 1'b1;
      end
    join
    wait_end(eb + 1);
    checks++;
    if (out_q.size() - qb != 8) begin
      errors++; $display("FAIL bp_count: got %0d outputs, want 8", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i] || last_q[qb+i] !== (i == 7)) begin
          errors++;
          $display("FAIL bp_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i]), i == 7);
        end
      end
    end
    checks++; if (beat_cnt - bb != 50) begin errors++; $display("FAIL bp_beats: got %0d, want 50", beat_cnt - bb); end
  endtask

  task automatic test_restart();
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
    int qb = out_q.size();
    int eb = end_cnt;
    int bb = beat_cnt;
    out_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 13; i++) drive_beat(pix(0, 0, i / IFM, i % IFM));
    checks++;
    if (out_valid !== 1'b1 || data_output !== 32'd12) begin
      errors++; $display("FAIL rs_pending: got valid=%b data=%0d, want 1 12", out_valid, $signed(data_output));
    end
    start_pool = 1'b1;
    in_valid   = 1'b1;
    ifm        = 32'd999;
    @(posedge clk1); #1;
    start_pool = 1'b0;
    in_valid   = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_flush: got out_valid=%b, want 0", out_valid); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rs_busy: got %b, want 1", busy); end
    out_ready = 1'b1;
    send_frame(0);
    wait_end(eb + 1);
    repeat (5) @(posedge clk1);
    #1;
    checks++;
    if (out_q.size() - qb != 8) begin
      errors++; $display("FAIL rs_count: got %0d outputs, want 8", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i] || last_q[qb+i] !== (i == 7)) begin
          errors++;
          $display("FAIL rs_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i]), i == 7);
        end
      end
    end
    checks++; if (end_cnt - eb != 1)   begin errors++; $display("FAIL rs_end_cnt: got %0d, want 1", end_cnt - eb); end
    checks++; if (beat_cnt - bb != 63) begin errors++; $display("FAIL rs_beats: got %0d, want 63", beat_cnt - bb); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
    int eb = end_cnt;
    int qb, bb;
    out_ready = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 20; i++) drive_beat(pix(0, 0, i / IFM, i % IFM));
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rm_in_ready: got %b, want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b, want 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rm_out_last: got %b, want 0", out_last); end
    checks++; if (end_pool !== 1'b0)  begin errors++; $display("FAIL rm_end_pool: got %b, want 0", end_pool); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b, want 0", busy); end
    checks++; if (data_output !== '0) begin errors++; $display("FAIL rm_data: got %0d, want 0", $signed(data_output)); end
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++; if (end_cnt != eb) begin errors++; $display("FAIL rm_no_end: got %0d end_pool, want 0", end_cnt - eb); end
    bb = beat_cnt;
    in_valid = 1'b1;
    ifm      = 32'd77;
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if (in_ready !== 1'b0 || beat_cnt != bb) begin
      errors++; $display("FAIL rm_idle_ignore: got in_ready=%b beats=%0d, want 0 0", in_ready, beat_cnt - bb);
    end
    in_valid = 1'b0;
    qb = out_q.size();
    do_start(1'b0);
    send_frame(0);
    wait_end(eb + 1);
    checks++;
    if (out_q.size() - qb != 8) begin
      errors++; $display("FAIL rm_count: got %0d outputs, want 8", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i] || last_q[qb+i] !== (i == 7)) begin
          errors++;
          $display("FAIL rm_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i]), i == 7);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [8] = '{12, 14, 22, 24, 12, 14, 22, 24};
    int qb = out_q.size();
    int eb = end_cnt;
    out_ready = 1'b1;
    do_start(1'b0);
    send_frame(0);
    // Last output is now pending; restart in the cycle it is accepted.
    start_pool = 1'b1;
    @(negedge clk1);
    checks++;
    if (end_pool !== 1'b1 || out_last !== 1'b1) begin
      errors++; $display("FAIL b2b_end_pool: got end_pool=%b out_last=%b, want 1 1", end_pool, out_last);
    end
    @(posedge clk1); #1;
    start_pool = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_rerun: got busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    send_frame(0);
    wait_end(eb + 2);
    checks++;
    if (out_q.size() - qb != 16) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, want 16", out_q.size() - qb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (out_q[qb+i] !== exp[i%8] || last_q[qb+i] !== (i % 8 == 7)) begin
          errors++;
          $display("FAIL b2b_out%0d: got %0d last=%b, want %0d last=%b",
                   i, $signed(out_q[qb+i]), last_q[qb+i], $signed(exp[i%8]), i % 8 == 7);
        end
      end
    end
    checks++; if (end_cnt - eb != 2) begin errors++; $display("FAIL b2b_end_cnt: got %0d, want 2", end_cnt - eb); end
    checks++; if (bad_end != 0)      begin errors++; $display("FAIL b2b_end_align: got %0d stray end_pool, want 0", bad_end); end
  endtask

  initial begin
    test_reset();
    test_max_ramp();
    test_avg_ramp();
    test_negative();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, signed pixel width.
- IFM_SIZE, 27, input plane edge (square).
- KERNEL_POOL, 3, window edge, legal range 2..IFM_SIZE.
- STRIDE_POOL, 2, window step, at least 1.
- CI, 8, channels per frame.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk1, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start_pool, in, 1, one-cycle frame start pulse.
- avg_mode, in, 1, 0 = max, 1 = average; sampled on start_pool.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, input beat accepted when high together with in_valid.
- ifm, in, DATA_WIDTH, input pixel.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accept.
- data_output, out, DATA_WIDTH, pooled pixel.
- out_last, out, 1, final output of the frame.
- end_pool, out, 1, one-cycle done pulse.
- busy, out, 1, frame in progress.

Function
REQ-003 Input order: CI planes in sequence; each plane is IFM_SIZE x IFM_SIZE, row-major; col, row and ch counters wrap in that order.
REQ-004 OFM_SIZE = (IFM_SIZE-KERNEL_POOL)/STRIDE_POOL+1; the frame emits CI*OFM_SIZE^2 outputs in channel, row, column order.
REQ-005 Window storage: KERNEL_POOL-1 line buffers of IFM_SIZE entries each, plus a KERNEL_POOL x KERNEL_POOL register window; all are cleared at every plane start.
REQ-006 An output is produced on the accepted beat (r,c) when r and c are both at least K-1 and (r-K+1)%S = 0 and (c-K+1)%S = 0, where K = KERNEL_POOL and S = STRIDE_POOL.
REQ-007 Latency: out_valid rises on the cycle after the completing beat is accepted.
REQ-008 The output stage is a single register; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-009 Output handshake: data_output, out_valid and out_last hold stable while out_valid && !out_ready.
REQ-010 Max mode: signed maximum of K^2 pixels.
REQ-011 Average mode: signed sum in DATA_WIDTH+clog2(K^2) bits, divided by K^2, truncated toward zero, with the low DATA_WIDTH bits output.
REQ-012 FSM states:
- IDLE: goes to RUN on start_pool.
- RUN: goes to DONE when the last beat (ch=CI-1, r=c=IFM_SIZE-1) is accepted.
- DONE: goes to IDLE on the out_last handshake, with end_pool pulsed in that cycle.
REQ-013 busy is high in RUN and DONE.
REQ-014 start_pool in RUN or DONE restarts the frame: counters and windows clear, the output register is invalidated, and any in_valid beat in that cycle is not accepted.
REQ-015 start_pool in the same cycle as an out_last handshake: end_pool still pulses and the FSM enters RUN.
REQ-016 in_valid while in IDLE or DONE is ignored.

Reset
REQ-017 While rst_n is low:
- FSM is in IDLE; counters, window and line-buffer valid state are zero.
- in_ready, out_valid, out_last, end_pool and busy are 0; data_output is 0.
REQ-018 Reset asserted mid-frame aborts the frame with no end_pool; operation resumes only on a new start_pool.

Configuration
REQ-019 With POOL_ENGINE_AVG_EN defined: avg_mode is honoured and the sum/divide datapath is present.
REQ-020 Without POOL_ENGINE_AVG_EN: avg_mode is ignored, max mode is always used, and no adder or divider is synthesised.

Structure
REQ-021 Package pool_engine_pkg holds:
- the FSM state enum (IDLE, RUN, DONE);
- the OFM_SIZE function;
- a clog2 function;
- the sum-width constant function.
REQ-022 Sub-module pool_line_buffer: parameterised DATA_WIDTH x IFM_SIZE delay line with a shift enable and a synchronous clear, instantiated KERNEL_POOL-1 times.

Verification
All scenarios use IFM_SIZE=5, KERNEL_POOL=3, STRIDE_POOL=2, CI=2 unless stated otherwise.
REQ-023 Max mode, pixel = 5r+c in both planes, out_ready=1 -> outputs 12,14,22,24,12,14,22,24; out_last on the 8th output; end_pool in the same cycle.
REQ-024 Average mode, same ramp -> outputs 6,8,16,18 per plane. Plane of all -7 -> -7 in both modes. Window sum -8 -> avg 0.
REQ-025 Backpressure: out_ready held low for 10 cycles after the first output -> in_ready low, data_output stable at 12, no beat lost or duplicated.
REQ-026 Restart: start_pool after 13 beats, then a full ramp frame -> only the 8 expected outputs appear and exactly one end_pool.
REQ-027 Reset: rst_n low mid-frame -> all outputs are 0 within the reset; a new frame then completes correctly.
REQ-028 Build without POOL_ENGINE_AVG_EN and avg_mode=1 -> max-mode results as in REQ-023.
